reg_file: RTL and testbench

- General-purpose register file for the toy MIPS pipeline.
- Answers the decode stage's two combinational read requests (left/right).
- Takes one write-back per cycle from the MEM/WB end of the pipeline.
- Keeps a per-register pending-write scoreboard, so decode can tell when a source register has an in-flight producer it cannot yet forward from.

---
 rtl/reg_file_if.sv | 44 ++++
 rtl/reg_file.sv | 91 +++++++++
 tb/tb_reg_file.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: decode/write-back bus of the register file.
//   master : pipeline side -- drives read addresses, write-back and issue requests.
//   slave  : register file -- returns read data, pending flags and the pending count.
//   read_addr_*/read_value_*/read_pending_* : two combinational decode read ports.
//   write_enable/write_addr/write_value     : one write-back per cycle.
//   issue_enable/issue_dest                 : marks a destination as having an in-flight producer.
//   pending_count                           : registered number of pending registers.
interface reg_file_if #(
    parameter int REG_NUM        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WORD_WIDTH     = 32
);
    localparam int COUNT_WIDTH = $clog2(REG_NUM + 1);
    logic [REG_ADDR_WIDTH-1:0] read_addr_left;
    logic [REG_ADDR_WIDTH-1:0] read_addr_right;
    logic [WORD_WIDTH-1:0]     read_value_left;
    logic [WORD_WIDTH-1:0]     read_value_right;
    logic                      read_pending_left;
    logic                      read_pending_right;
    logic                      write_enable;
    logic [REG_ADDR_WIDTH-1:0] write_addr;
    logic [WORD_WIDTH-1:0]     write_value;
    logic                      issue_enable;
    logic [REG_ADDR_WIDTH-1:0] issue_dest;
    logic [COUNT_WIDTH-1:0]    pending_count;

    modport master (
        output read_addr_left, read_addr_right,
        output write_enable, write_addr, write_value,
        output issue_enable, issue_dest,
        input  read_value_left, read_value_right,
        input  read_pending_left, read_pending_right,
        input  pending_count
    );

    modport slave (
        input  read_addr_left, read_addr_right,
        input  write_enable, write_addr, write_value,
        input  issue_enable, issue_dest,
        output read_value_left, read_value_right,
        output read_pending_left, read_pending_right,
        output pending_count
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: MIPS general-purpose register file with a pending-write scoreboard.
//   clk : pipeline clock, all state updates on the rising edge.
//   rst : asynchronous active-high reset; clears registers, pending bits and count.
//   bus : reg_file_if.slave -- two combinational read ports with pending flags,
//         one write-back port, one issue port and the registered pending count.
// Register 0 reads as zero, ignores writes and is never pending.
// Optional macro REG_FILE_BYPASS_EN: same-cycle write-back is forwarded to the
// read ports, and a forwarded read reports not-pending unless re-issued this cycle.
module reg_file #(
    parameter int REG_NUM        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WORD_WIDTH     = 32
) (
    input logic        clk,
    input logic        rst,
    reg_file_if.slave  bus
);
    localparam int COUNT_WIDTH = $clog2(REG_NUM + 1);

    logic [WORD_WIDTH-1:0]  regs [REG_NUM];
    logic [REG_NUM-1:0]     pending;
    logic [REG_NUM-1:0]     pending_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   write_live;

    assign write_live = bus.write_enable && bus.write_addr != '0;

    // Issue sets, write-back clears; an issue in the same cycle wins because
    // the newer producer is still outstanding. The count is taken from the
    // next-state bits so it moves on the same edge.
    always_comb begin
        pending_next = '0;
        count_next   = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            pending_next[r] = (bus.issue_enable && bus.issue_dest == REG_ADDR_WIDTH'(r)) ||
                              (pending[r] && !(bus.write_enable && bus.write_addr == REG_ADDR_WIDTH'(r)));
            count_next      = count_next + COUNT_WIDTH'(pending_next[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pending_next;
            count   <= count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (write_live) begin
            regs[bus.write_addr] <= bus.write_value;
        end
    end

    assign bus.pending_count = count;

`ifdef REG_FILE_BYPASS_EN
    logic fwd_left;
    logic fwd_right;
    logic reissue_left;
    logic reissue_right;

    assign fwd_left      = write_live && bus.write_addr == bus.read_addr_left;
    assign fwd_right     = write_live && bus.write_addr == bus.read_addr_right;
    assign reissue_left  = bus.issue_enable && bus.issue_dest == bus.read_addr_left;
    assign reissue_right = bus.issue_enable && bus.issue_dest == bus.read_addr_right;

    always_comb begin
        bus.read_value_left    = bus.read_addr_left == '0 ? '0 :
                                 fwd_left ? bus.write_value : regs[bus.read_addr_left];
        bus.read_value_right   = bus.read_addr_right == '0 ? '0 :
                                 fwd_right ? bus.write_value : regs[bus.read_addr_right];
        bus.read_pending_left  = bus.read_addr_left != '0 &&
                                 (fwd_left ? reissue_left : pending[bus.read_addr_left]);
        bus.read_pending_right = bus.read_addr_right != '0 &&
                                 (fwd_right ? reissue_right : pending[bus.read_addr_right]);
    end
`else
    always_comb begin
        bus.read_value_left    = bus.read_addr_left == '0 ? '0 : regs[bus.read_addr_left];
        bus.read_value_right   = bus.read_addr_right == '0 ? '0 : regs[bus.read_addr_right];
        bus.read_pending_left  = bus.read_addr_left != '0 && pending[bus.read_addr_left];
        bus.read_pending_right = bus.read_addr_right != '0 && pending[bus.read_addr_right];
    end
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_file_if bus ();
    reg_file dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.write_enable = 1'b0;
        bus.issue_enable = 1'b0;
        bus.write_addr   = '0;
        bus.write_value  = '0;
        bus.issue_dest   = '0;
    endtask

    task automatic test_reset();
        bus.read_addr_left  = 5'd5;
        bus.read_addr_right = 5'd31;
        #1;
        checks++;
        if (bus.read_value_left !== 32'h0 || bus.read_value_right !== 32'h0) begin
            errors++;
            $display("FAIL reset_read: got %h/%h expected 0/0", bus.read_value_left, bus.read_value_right);
        end
        checks++;
        if (bus.pending_count !== 6'd0 || bus.read_pending_left !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending: got count %0d pend %b expected 0 0", bus.pending_count, bus.read_pending_left);
        end
    endtask

    task automatic test_write_read();
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd3;
        bus.write_value  = 32'hDEADBEEF;
        cycle();
        idle();
        bus.read_addr_left  = 5'd3;
        bus.read_addr_right = 5'd3;
        #1;
        checks++;
        if (bus.read_value_left !== 32'hDEADBEEF || bus.read_value_right !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read_r3: got %h/%h expected deadbeef/deadbeef", bus.read_value_left, bus.read_value_right);
        end
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd0;
        bus.write_value  = 32'hFFFFFFFF;
        cycle();
        idle();
        bus.read_addr_left  = 5'd0;
        bus.read_addr_right = 5'd0;
        #1;
        checks++;
        if (bus.read_value_left !== 32'h0 || bus.read_value_right !== 32'h0 || bus.read_pending_left !== 1'b0) begin
            errors++;
            $display("FAIL write_r0: got %h/%h pend %b expected 0/0 pend 0", bus.read_value_left, bus.read_value_right, bus.read_pending_left);
        end
    endtask

    task automatic test_same_cycle();
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd7;
        bus.write_value  = 32'h11;
        cycle();
        bus.write_value     = 32'h55;
        bus.read_addr_left  = 5'd7;
        bus.read_addr_right = 5'd3;
        #1;
        checks++;
`ifdef REG_FILE_BYPASS_EN
        if (bus.read_value_left !== 32'h55) begin
            errors++;
            $display("FAIL same_cycle_bypass: got %h expected 00000055", bus.read_value_left);
        end
`else
        if (bus.read_value_left !== 32'h11) begin
            errors++;
            $display("FAIL same_cycle_stored: got %h expected 00000011", bus.read_value_left);
        end
`endif
        cycle();
        idle();
        #1;
        checks++;
        if (bus.read_value_left !== 32'h55 || bus.read_value_right !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL same_cycle_next: got %h/%h expected 00000055/deadbeef", bus.read_value_left, bus.read_value_right);
        end
    endtask

    task automatic test_scoreboard();
        bus.issue_enable = 1'b1;
        bus.issue_dest   = 5'd9;
        cycle();
        idle();
        bus.read_addr_left  = 5'd9;
        bus.read_addr_right = 5'd8;
        #1;
        checks++;
        if (bus.read_pending_left !== 1'b1 || bus.read_pending_right !== 1'b0 || bus.pending_count !== 6'd1) begin
            errors++;
            $display("FAIL issue_r9: got pend %b/%b count %0d expected 1/0 count 1", bus.read_pending_left, bus.read_pending_right, bus.pending_count);
        end
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd9;
        bus.write_value  = 32'hA5A5_0009;
        cycle();
        idle();
        #1;
        checks++;
        if (bus.read_pending_left !== 1'b0 || bus.pending_count !== 6'd0 || bus.read_value_left !== 32'hA5A5_0009) begin
            errors++;
            $display("FAIL writeback_r9: got pend %b count %0d val %h expected 0 0 a5a50009", bus.read_pending_left, bus.pending_count, bus.read_value_left);
        end
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd8;
        bus.write_value  = 32'h8;
        cycle();
        idle();
        #1;
        checks++;
        if (bus.pending_count !== 6'd0 || bus.read_pending_right !== 1'b0 || bus.read_value_right !== 32'h8) begin
            errors++;
            $display("FAIL write_nonpending: got count %0d pend %b val %h expected 0 0 00000008", bus.pending_count, bus.read_pending_right, bus.read_value_right);
        end
    endtask

    task automatic test_set_wins();
        bus.issue_enable = 1'b1;
        bus.issue_dest   = 5'd4;
        cycle();
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd4;
        bus.write_value  = 32'hCAFE;
        cycle();
        idle();
        bus.read_addr_left  = 5'd4;
        bus.read_addr_right = 5'd4;
        #1;
        checks++;
        if (bus.read_pending_left !== 1'b1 || bus.read_pending_right !== 1'b1 || bus.pending_count !== 6'd1) begin
            errors++;
            $display("FAIL set_wins_pending: got pend %b/%b count %0d expected 1/1 count 1", bus.read_pending_left, bus.read_pending_right, bus.pending_count);
        end
        checks++;
        if (bus.read_value_left !== 32'hCAFE) begin
            errors++;
            $display("FAIL set_wins_value: got %h expected 0000cafe", bus.read_value_left);
        end
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd4;
        bus.write_value  = 32'hBEEF;
        cycle();
        idle();
        #1;
        checks++;
        if (bus.read_pending_left !== 1'b0 || bus.pending_count !== 6'd0) begin
            errors++;
            $display("FAIL set_wins_clear: got pend %b count %0d expected 0 0", bus.read_pending_left, bus.pending_count);
        end
    endtask

    task automatic test_count_sweep();
        for (int d = 1; d < 32; d++) begin
            bus.issue_enable = 1'b1;
            bus.issue_dest   = 5'(d);
            cycle();
            #1;
            checks++;
            if (bus.pending_count !== 6'(d)) begin
                errors++;
                $display("FAIL sweep_set_%0d: got count %0d expected %0d", d, bus.pending_count, d);
            end
        end
        bus.issue_dest = 5'd0;
        cycle();
        idle();
        bus.read_addr_left  = 5'd0;
        bus.read_addr_right = 5'd31;
        #1;
        checks++;
        if (bus.pending_count !== 6'd31 || bus.read_pending_left !== 1'b0 || bus.read_pending_right !== 1'b1) begin
            errors++;
            $display("FAIL sweep_issue_r0: got count %0d pend %b/%b expected 31 0/1", bus.pending_count, bus.read_pending_left, bus.read_pending_right);
        end
        for (int d = 1; d < 32; d++) begin
            bus.write_enable = 1'b1;
            bus.write_addr   = 5'(d);
            bus.write_value  = 32'(d) << 4;
            cycle();
        end
        idle();
        #1;
        checks++;
        if (bus.pending_count !== 6'd0 || bus.read_pending_right !== 1'b0 || bus.read_value_right !== 32'h1F0) begin
            errors++;
            $display("FAIL sweep_clear: got count %0d pend %b val %h expected 0 0 000001f0", bus.pending_count, bus.read_pending_right, bus.read_value_right);
        end
    endtask

    task automatic test_async_reset();
        bus.write_enable = 1'b1;
        bus.write_addr   = 5'd5;
        bus.write_value  = 32'h1234;
        bus.issue_enable = 1'b1;
        bus.issue_dest   = 5'd6;
        cycle();
        idle();
        bus.read_addr_left  = 5'd5;
        bus.read_addr_right = 5'd6;
        #1;
        checks++;
        if (bus.read_value_left !== 32'h1234 || bus.read_pending_right !== 1'b1 || bus.pending_count !== 6'd1) begin
            errors++;
            $display("FAIL pre_reset: got %h pend %b count %0d expected 00001234 1 1", bus.read_value_left, bus.read_pending_right, bus.pending_count);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.read_value_left !== 32'h0 || bus.read_pending_right !== 1'b0 || bus.pending_count !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: got %h pend %b count %0d expected 0 0 0", bus.read_value_left, bus.read_pending_right, bus.pending_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle();
        bus.read_addr_left  = '0;
        bus.read_addr_right = '0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_write_read();
        test_same_cycle();
        test_scoreboard();
        test_set_wins();
        test_count_sweep();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
